serialtl_mem_responder: RTL and testbench
=========================================

Name: serialtl_mem_responder

Overview:
- Manager-side endpoint for SerialTL traffic initiated by SCuM-V.
- Sits between the GenericDeserializer output and the GenericSerializer input on the FPGA.
- Consumes channel-A frames (Get / PutFullData / PutPartialData) and services them against a local 64-bit-wide block RAM.
- Emits channel-D frames (AccessAck / AccessAckData) back toward the chip, so SCuM-V can use FPGA-backed memory.

Parameters:
- MEM_WORDS, 1024, depth of the backing RAM in 64-bit words (power of two).
- ADDR_BASE, 64'h8000_0000, byte address of RAM word 0.
- MAX_SIZE, 6, largest accepted log2 transfer size (6 = 64 B = 8 beats).

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  inbound frame valid.
- req_ready  out  1  inbound frame accepted.
- req_chanId/opcode/param  in  3 each  frame header fields.
- req_size/req_source  in  8 each  log2 bytes / requester id.
- req_address/req_data  in  64 each  byte address / beat data.
- req_corrupt  in  1  beat corrupt flag.
- req_union  in  9  channel A: [7:0] = byte mask.
- req_last  in  1  final beat of the message.
- rsp_valid  out  1  outbound frame valid.
- rsp_ready  in  1  outbound frame accepted.
- rsp_chanId/opcode/param  out  3 each  response header fields.
- rsp_size/rsp_source  out  8 each  echoed from the request.
- rsp_address/rsp_data  out  64 each  address is 0; data is read data.
- rsp_corrupt  out  1  always 0.
- rsp_union  out  9  [0] = denied; all other bits 0.
- rsp_last  out  1  final beat.
- dbg_state  out  3  FSM state encoding.
- dbg_drop_count  out  8  saturating count of discarded frames.

Behaviour:
- Reset (clk edge with reset_n=0): all outputs 0; FSM to IDLE; dbg_drop_count to 0. Any in-flight transaction is abandoned and no response is sent. A reset asserted mid-operation takes effect on the same edge.
- Handshake: a transfer occurs on a cycle with valid && ready. While rsp_valid=1, all rsp_* fields are held stable until rsp_ready. req_ready never depends combinationally on rsp_ready.
- States: IDLE, PUT_BEAT, READ, GET_RESP, ACK.
- IDLE: req_ready=1. On an accepted frame:
  - chanId!=0 → discard; dbg_drop_count+1, saturating at 255.
  - opcode 0 or 1 with size<=MAX_SIZE and in range → write beat; go to PUT_BEAT if last=0, else ACK.
  - opcode 4 → latch source/size/address; beat counter = 0; go to READ.
  - Any other opcode, or size>MAX_SIZE → discard and count (see Optional Feature).
- Range check: word index = (address-ADDR_BASE)>>3. In range iff address>=ADDR_BASE and index+beats<=MEM_WORDS, where beats = max(1, 2^size/8). Out-of-range Put: no RAM write, but ACK is still sent with denied=1. Out-of-range Get: beats are sent with data 0 and denied=1.
- Writes: per-byte enable = union[7:0]. PutFullData ignores the mask and writes all 8 bytes.
  - Sub-word Get/Put (size<3) uses address[2:0] only via the mask. Read returns the full word.
- PUT_BEAT: req_ready=1. Each accepted beat writes to word index+beat. If a frame has chanId!=0 during a burst, it is dropped and counted; the burst continues. On the beat with last=1 → ACK.
- READ: one-cycle synchronous RAM read. Then GET_RESP with rsp_valid=1.
- GET_RESP: chanId=3, opcode=1, data=RAM word, last=(beat==beats-1). On handshake, if not last: beat+1 → READ; otherwise → IDLE.
- ACK: chanId=3, opcode=0, last=1, size/source echoed. On handshake → IDLE.
- req_ready=0 in READ, GET_RESP, and ACK.
- Latency:
  - Single-beat Put: accept → rsp_valid is 1 cycle.
  - Get: accept → first rsp_valid is 2 cycles; each subsequent beat is 2 cycles after the previous handshake.
- Burst beat count and address wrap: the index never wraps; out-of-range is detected up front at the first beat.

Optional Feature:
- Macro: SERIALTL_RESP_DENY_UNSUPPORTED_EN.
- Defined: an unsupported opcode (Arithmetic/Logical/Hint) or size>MAX_SIZE on channel A produces a single denied response:
  - AccessAck if opcode<4, else AccessAckData with data 0;
  - rsp_union[0]=1, last=1.
  - The drop counter is not incremented.
- Undefined: such frames are silently discarded and dbg_drop_count is incremented.

Decomposition:
- Package serialtl_pkg holds:
  - chanId constants (CH_A=0, CH_D=3);
  - opcode constants (PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACK=0, ACK_DATA=1);
  - field widths;
  - the FSM state enum.
- One sub-module is natural: serialtl_mem_bram, a byte-masked single-port RAM with synchronous read, MEM_WORDS x 64.

Test Plan:
- Put then Get, single beat:
  - PutFull addr 0x8000_0010, size 3, data 0xDEADBEEF_CAFEF00D, source 5 → one D frame: opcode 0, source 5, denied 0.
  - Get of the same address → opcode 1, data 0xDEADBEEF_CAFEF00D, last 1.
- Partial mask: PutPartial mask 0x0F, data 0x11111111_22222222 over a word preloaded with all 0xFF → Get returns 0xFFFFFFFF_22222222.
- Burst:
  - PutFull size 5 (4 beats) with data 1,2,3,4 → exactly one AccessAck after the 4th beat.
  - Get size 5 → 4 beats with data 1..4, last only on beat 4.
- Backpressure: hold rsp_ready=0 for 10 cycles during a Get → rsp fields stable; req_ready=0; no beat lost or duplicated.
- Out of range and drops:
  - Get at 0x0000_1000 → data 0, rsp_union[0]=1.
  - Frame with chanId 2 → no response; dbg_drop_count 0→1.
- Reset mid-burst: reset_n=0 for 1 cycle after the 2nd of 4 Put beats → outputs 0, state IDLE, no ACK emitted. A fresh Get then works normally.

Source files
------------

// File: rtl/serialtl_pkg.sv
// Shared SerialTL constants, field widths and FSM state encoding
// for the FPGA-side memory responder.
package serialtl_pkg;

    localparam int CHAN_W  = 3;
    localparam int OP_W    = 3;
    localparam int PARAM_W = 3;
    localparam int SIZE_W  = 8;
    localparam int SRC_W   = 8;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int UNION_W = 9;
    localparam int MASK_W  = 8;

    localparam logic [CHAN_W-1:0] CH_A = 3'd0;
    localparam logic [CHAN_W-1:0] CH_D = 3'd3;

    localparam logic [OP_W-1:0] PUT_FULL    = 3'd0;
    localparam logic [OP_W-1:0] PUT_PARTIAL = 3'd1;
    localparam logic [OP_W-1:0] GET         = 3'd4;
    localparam logic [OP_W-1:0] ACK         = 3'd0;
    localparam logic [OP_W-1:0] ACK_DATA    = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUT_BEAT = 3'd1,
        ST_READ     = 3'd2,
        ST_GET_RESP = 3'd3,
        ST_ACK      = 3'd4
    } state_t;

    // Beats in a transfer of 2^size bytes on a 64-bit bus.
    // Sizes above 10 do not fit the counter and are never accepted.
    function automatic logic [7:0] beats_of(input logic [SIZE_W-1:0] size);
        if (size < 8'd3) return 8'd1;
        if (size > 8'd10) return 8'd0;
        return 8'd1 << (size - 8'd3);
    endfunction

endpackage

// File: rtl/serialtl_mem_bram.sv
// Byte-masked single-port RAM, WORDS x 64, synchronous read.
// Ports: clk, en, we, be (byte enables), addr, wdata, rdata (held when idle).
module serialtl_mem_bram
    import serialtl_pkg::*;
#(
    parameter int unsigned WORDS = 1024
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [MASK_W-1:0]          be,
    input  logic [$clog2(WORDS)-1:0]   addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < MASK_W; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/serialtl_mem_responder.sv
// SerialTL manager endpoint: services channel-A Get/Put against a local
// 64-bit RAM and returns channel-D AccessAck/AccessAckData frames.
// Ports: clk, reset_n (sync, active-low); req_* inbound frame with
// valid/ready; rsp_* outbound frame with valid/ready; dbg_state,
// dbg_drop_count (saturating discarded-frame count).
// Option: SERIALTL_RESP_DENY_UNSUPPORTED_EN answers unsupported opcodes
// and oversize requests with a denied response instead of dropping them.
module serialtl_mem_responder
    import serialtl_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
    parameter int unsigned MAX_SIZE  = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CHAN_W-1:0]  req_chanId,
    input  logic [OP_W-1:0]    req_opcode,
    input  logic [PARAM_W-1:0] req_param,
    input  logic [SIZE_W-1:0]  req_size,
    input  logic [SRC_W-1:0]   req_source,
    input  logic [ADDR_W-1:0]  req_address,
    input  logic [DATA_W-1:0]  req_data,
    input  logic               req_corrupt,
    input  logic [UNION_W-1:0] req_union,
    input  logic               req_last,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [CHAN_W-1:0]  rsp_chanId,
    output logic [OP_W-1:0]    rsp_opcode,
    output logic [PARAM_W-1:0] rsp_param,
    output logic [SIZE_W-1:0]  rsp_size,
    output logic [SRC_W-1:0]   rsp_source,
    output logic [ADDR_W-1:0]  rsp_address,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_corrupt,
    output logic [UNION_W-1:0] rsp_union,
    output logic               rsp_last,
    output logic [2:0]         dbg_state,
    output logic [7:0]         dbg_drop_count
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [SIZE_W-1:0] MAX_SZ = SIZE_W'(MAX_SIZE);

    state_t state_q, state_d;

    logic [SRC_W-1:0]  src_q;
    logic [SIZE_W-1:0] size_q;
    logic [AW-1:0]     base_q;
    logic [7:0]        beat_q;
    logic [7:0]        beats_q;
    logic              denied_q;
    logic              full_q;
    logic [OP_W-1:0]   ack_op_q;
    logic [7:0]        drop_q;

    logic ld_put, ld_get, ld_unsup, beat_inc, drop_inc;

    logic              mem_en, mem_we;
    logic [MASK_W-1:0] mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // Request decode; acc qualifies on reset_n so nothing is
    // accepted or written while reset is held.
    logic              acc;
    logic              is_a, is_put, is_get, size_ok, in_range;
    logic [63:0]       req_off, req_idx;
    logic [7:0]        req_beats;
    logic [AW-1:0]     cur_idx;

    assign acc       = req_valid && reset_n;
    assign is_a      = req_chanId == CH_A;
    assign is_put    = req_opcode == PUT_FULL || req_opcode == PUT_PARTIAL;
    assign is_get    = req_opcode == GET;
    assign size_ok   = req_size <= MAX_SZ;
    assign req_off   = req_address - ADDR_BASE;
    assign req_idx   = req_off >> 3;
    assign req_beats = beats_of(req_size);
    assign in_range  = (req_address >= ADDR_BASE) &&
                       (req_idx + 64'(req_beats) <= 64'(MEM_WORDS));
    assign cur_idx   = base_q + AW'(beat_q);

    logic unused_ok;
    assign unused_ok = ^{req_param, req_corrupt, req_union[8]};

    serialtl_mem_bram #(.WORDS(MEM_WORDS)) u_bram (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (mem_addr),
        .wdata (req_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_chanId  = '0;
        rsp_opcode  = '0;
        rsp_param   = '0;
        rsp_size    = '0;
        rsp_source  = '0;
        rsp_address = '0;
        rsp_data    = '0;
        rsp_corrupt = 1'b0;
        rsp_union   = '0;
        rsp_last    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_be      = '0;
        mem_addr    = cur_idx;
        ld_put      = 1'b0;
        ld_get      = 1'b0;
        ld_unsup    = 1'b0;
        beat_inc    = 1'b0;
        drop_inc    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = reset_n;
                if (acc) begin
                    if (!is_a) begin
                        drop_inc = 1'b1;
                    end else if (is_put && size_ok) begin
                        ld_put   = 1'b1;
                        mem_en   = in_range;
                        mem_we   = in_range;
                        mem_addr = req_idx[AW-1:0];
                        mem_be   = (req_opcode == PUT_FULL) ? 8'hFF
                                                            : req_union[7:0];
                        state_d  = req_last ? ST_ACK : ST_PUT_BEAT;
                    end else if (is_get && size_ok) begin
                        ld_get  = 1'b1;
                        state_d = ST_READ;
                    end else begin
`ifdef SERIALTL_RESP_DENY_UNSUPPORTED_EN
                        ld_unsup = 1'b1;
                        state_d  = ST_ACK;
`else
                        drop_inc = 1'b1;
`endif
                    end
                end
            end
            ST_PUT_BEAT: begin
                req_ready = reset_n;
                if (acc) begin
                    if (!is_a) begin
                        drop_inc = 1'b1;
                    end else begin
                        // Surplus beats past the declared size are
                        // swallowed so the index can never run off the end.
                        beat_inc = 1'b1;
                        if (!denied_q && beat_q < beats_q) begin
                            mem_en = 1'b1;
                            mem_we = 1'b1;
                            mem_be = full_q ? 8'hFF : req_union[7:0];
                        end
                        if (req_last) state_d = ST_ACK;
                    end
                end
            end
            ST_READ: begin
                mem_en  = 1'b1;
                state_d = ST_GET_RESP;
            end
            ST_GET_RESP: begin
                rsp_valid  = 1'b1;
                rsp_chanId = CH_D;
                rsp_opcode = ACK_DATA;
                rsp_size   = size_q;
                rsp_source = src_q;
                rsp_data   = denied_q ? '0 : mem_rdata;
                rsp_union  = {8'd0, denied_q};
                rsp_last   = beat_q == beats_q - 8'd1;
                if (rsp_ready) begin
                    if (rsp_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_inc = 1'b1;
                        state_d  = ST_READ;
                    end
                end
            end
            ST_ACK: begin
                rsp_valid  = 1'b1;
                rsp_chanId = CH_D;
                rsp_opcode = ack_op_q;
                rsp_size   = size_q;
                rsp_source = src_q;
                rsp_union  = {8'd0, denied_q};
                rsp_last   = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q    <= '0;
            size_q   <= '0;
            base_q   <= '0;
            beat_q   <= '0;
            beats_q  <= '0;
            denied_q <= 1'b0;
            full_q   <= 1'b0;
            ack_op_q <= ACK;
            drop_q   <= '0;
        end else begin
            if (ld_put || ld_get || ld_unsup) begin
                src_q   <= req_source;
                size_q  <= req_size;
                base_q  <= req_idx[AW-1:0];
                beats_q <= req_beats;
            end
            if (ld_put) begin
                beat_q   <= 8'd1;
                denied_q <= !in_range;
                full_q   <= req_opcode == PUT_FULL;
                ack_op_q <= ACK;
            end
            if (ld_get) begin
                beat_q   <= 8'd0;
                denied_q <= !in_range;
            end
            if (ld_unsup) begin
                denied_q <= 1'b1;
                ack_op_q <= (req_opcode < GET) ? ACK : ACK_DATA;
            end
            if (beat_inc) beat_q <= beat_q + 8'd1;
            if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign dbg_state      = state_q;
    assign dbg_drop_count = drop_q;

endmodule

// File: tb/tb_serialtl_mem_responder.sv
// Directed bench for serialtl_mem_responder: put/get, masks, bursts,
// backpressure, range checks, drops and reset mid-burst.
module tb_serialtl_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_chanId, req_opcode, req_param;
    logic [7:0]  req_size, req_source;
    logic [63:0] req_address, req_data;
    logic        req_corrupt;
    logic [8:0]  req_union;
    logic        req_last;
    logic        rsp_valid, rsp_ready;
    logic [2:0]  rsp_chanId, rsp_opcode, rsp_param;
    logic [7:0]  rsp_size, rsp_source;
    logic [63:0] rsp_address, rsp_data;
    logic        rsp_corrupt;
    logic [8:0]  rsp_union;
    logic        rsp_last;
    logic [2:0]  dbg_state;
    logic [7:0]  dbg_drop_count;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_drop = 0;

    localparam int RW = 164;
    logic [RW-1:0] rsp_all;
    logic [RW-1:0] g;

    always #5 clk = ~clk;

    assign rsp_all = {rsp_chanId, rsp_opcode, rsp_param, rsp_size,
                      rsp_source, rsp_address, rsp_data, rsp_corrupt,
                      rsp_union, rsp_last};

    serialtl_mem_responder dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_chanId(req_chanId), .req_opcode(req_opcode),
        .req_param(req_param), .req_size(req_size),
        .req_source(req_source), .req_address(req_address),
        .req_data(req_data), .req_corrupt(req_corrupt),
        .req_union(req_union), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_chanId(rsp_chanId), .rsp_opcode(rsp_opcode),
        .rsp_param(rsp_param), .rsp_size(rsp_size),
        .rsp_source(rsp_source), .rsp_address(rsp_address),
        .rsp_data(rsp_data), .rsp_corrupt(rsp_corrupt),
        .rsp_union(rsp_union), .rsp_last(rsp_last),
        .dbg_state(dbg_state), .dbg_drop_count(dbg_drop_count)
    );

    function automatic logic [RW-1:0] mk(input logic [2:0] op,
                                         input logic [7:0] sz,
                                         input logic [7:0] src,
                                         input logic [63:0] d,
                                         input logic den,
                                         input logic last);
        return {3'd3, op, 3'd0, sz, src, 64'd0, d, 1'b0, {8'd0, den}, last};
    endfunction

    task automatic send(input logic [2:0] ch, input logic [2:0] op,
                        input logic [7:0] sz, input logic [7:0] src,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] m, input logic last);
        int n = 0;
        @(negedge clk);
        req_chanId  = ch;
        req_opcode  = op;
        req_size    = sz;
        req_source  = src;
        req_address = a;
        req_data    = d;
        req_union   = {1'b0, m};
        req_last    = last;
        req_valid   = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL req_accept_timeout: req_ready=%b want 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [RW-1:0] got);
        int n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        got = rsp_all;
        if (rsp_valid !== 1'b1) begin
            vec_cnt++;
            err_cnt++;
            got = '0;
            $display("FAIL rsp_timeout: rsp_valid=%b want 1", rsp_valid);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({rsp_valid, req_ready, dbg_state, dbg_drop_count, rsp_all} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got v=%b r=%b st=%0d drop=%0d rsp=%h want all 0",
                     rsp_valid, req_ready, dbg_state, dbg_drop_count, rsp_all);
        end
        reset_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (req_ready !== 1'b1 || dbg_state !== 3'd0) begin
            err_cnt++;
            $display("FAIL reset_release: req_ready=%b st=%0d want 1/0",
                     req_ready, dbg_state);
        end
    endtask

    task automatic test_put_get_single();
        send(3'd0, 3'd0, 8'd3, 8'd5, 64'h8000_0010,
             64'hDEADBEEF_CAFEF00D, 8'h00, 1'b1);
        @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL put_latency: rsp_valid=%b want 1", rsp_valid);
        end
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd0, 8'd3, 8'd5, 64'd0, 1'b0, 1'b1)) begin
            err_cnt++;
            $display("FAIL put_ack: got %h want %h", g,
                     mk(3'd0, 8'd3, 8'd5, 64'd0, 1'b0, 1'b1));
        end
        send(3'd0, 3'd4, 8'd3, 8'd5, 64'h8000_0010, 64'd0, 8'h00, 1'b1);
        @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL get_lat_1: rsp_valid=%b req_ready=%b want 0/0",
                     rsp_valid, req_ready);
        end
        @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL get_lat_2: rsp_valid=%b want 1", rsp_valid);
        end
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd1, 8'd3, 8'd5, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1)) begin
            err_cnt++;
            $display("FAIL get_data: got %h want %h", g,
                     mk(3'd1, 8'd3, 8'd5, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1));
        end
    endtask

    task automatic test_partial_mask();
        send(3'd0, 3'd0, 8'd3, 8'd1, 64'h8000_0020, '1, 8'h00, 1'b1);
        wait_rsp(g);
        send(3'd0, 3'd1, 8'd3, 8'd1, 64'h8000_0020,
             64'h11111111_22222222, 8'h0F, 1'b1);
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd0, 8'd3, 8'd1, 64'd0, 1'b0, 1'b1)) begin
            err_cnt++;
            $display("FAIL partial_ack: got %h", g);
        end
        send(3'd0, 3'd4, 8'd3, 8'd1, 64'h8000_0020, 64'd0, 8'h00, 1'b1);
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd1, 8'd3, 8'd1, 64'hFFFFFFFF_22222222, 1'b0, 1'b1)) begin
            err_cnt++;
            $display("FAIL partial_data: got %h want data ffffffff22222222", g);
        end
    endtask

    task automatic test_burst();
        for (int i = 1; i <= 4; i++) begin
            send(3'd0, 3'd0, 8'd5, 8'd7, 64'h8000_0100, 64'(i), 8'h00, i == 4);
            if (i < 4) begin
                vec_cnt++;
                if (rsp_valid !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL burst_early_ack beat %0d: rsp_valid=%b want 0",
                             i, rsp_valid);
                end
            end
        end
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd0, 8'd5, 8'd7, 64'd0, 1'b0, 1'b1)) begin
            err_cnt++;
            $display("FAIL burst_ack: got %h", g);
        end
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL burst_extra_ack: rsp_valid=%b want 0", rsp_valid);
        end
        send(3'd0, 3'd4, 8'd5, 8'd7, 64'h8000_0100, 64'd0, 8'h00, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            wait_rsp(g);
            vec_cnt++;
            if (g !== mk(3'd1, 8'd5, 8'd7, 64'(i), 1'b0, i == 4)) begin
                err_cnt++;
                $display("FAIL burst_get beat %0d: got %h want %h", i, g,
                         mk(3'd1, 8'd5, 8'd7, 64'(i), 1'b0, i == 4));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] snap;
        logic stable;
        int n = 0;
        send(3'd0, 3'd4, 8'd4, 8'd3, 64'h8000_0100, 64'd0, 8'h00, 1'b1);
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        snap = rsp_all;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_all !== snap || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        vec_cnt++;
        if (stable !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_stable: rsp=%h v=%b rdy=%b want held %h/1/0",
                     rsp_all, rsp_valid, req_ready, snap);
        end
        vec_cnt++;
        if (snap !== mk(3'd1, 8'd4, 8'd3, 64'd1, 1'b0, 1'b0)) begin
            err_cnt++;
            $display("FAIL bp_beat0: got %h", snap);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd1, 8'd4, 8'd3, 64'd2, 1'b0, 1'b1)) begin
            err_cnt++;
            $display("FAIL bp_beat1: got %h", g);
        end
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_dup: rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_out_of_range();
        send(3'd0, 3'd4, 8'd3, 8'd9, 64'h0000_1000, 64'd0, 8'h00, 1'b1);
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd1, 8'd3, 8'd9, 64'd0, 1'b1, 1'b1)) begin
            err_cnt++;
            $display("FAIL oor_get: got %h", g);
        end
        send(3'd0, 3'd0, 8'd3, 8'd4, 64'h8000_1FF8,
             64'h01234567_89ABCDEF, 8'h00, 1'b1);
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd0, 8'd3, 8'd4, 64'd0, 1'b0, 1'b1)) begin
            err_cnt++;
            $display("FAIL last_word_put: got %h", g);
        end
        send(3'd0, 3'd0, 8'd4, 8'd4, 64'h8000_1FF8, 64'hBBBB, 8'h00, 1'b0);
        send(3'd0, 3'd0, 8'd4, 8'd4, 64'h8000_1FF8, 64'hCCCC, 8'h00, 1'b1);
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd0, 8'd4, 8'd4, 64'd0, 1'b1, 1'b1)) begin
            err_cnt++;
            $display("FAIL oor_put_ack: got %h", g);
        end
        send(3'd0, 3'd4, 8'd3, 8'd4, 64'h8000_1FF8, 64'd0, 8'h00, 1'b1);
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd1, 8'd3, 8'd4, 64'h01234567_89ABCDEF, 1'b0, 1'b1)) begin
            err_cnt++;
            $display("FAIL oor_put_nowrite: got %h", g);
        end
    endtask

    task automatic test_drops();
        send(3'd2, 3'd4, 8'd3, 8'd1, 64'h8000_0000, 64'd0, 8'h00, 1'b1);
        exp_drop++;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== 1'b0 || dbg_drop_count !== 8'(exp_drop)) begin
            err_cnt++;
            $display("FAIL drop_chan: v=%b drop=%0d want 0/%0d",
                     rsp_valid, dbg_drop_count, exp_drop);
        end
        send(3'd0, 3'd2, 8'd3, 8'd6, 64'h8000_0000, 64'd0, 8'h00, 1'b1);
`ifdef SERIALTL_RESP_DENY_UNSUPPORTED_EN
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd0, 8'd3, 8'd6, 64'd0, 1'b1, 1'b1)) begin
            err_cnt++;
            $display("FAIL unsup_op: got %h", g);
        end
`else
        exp_drop++;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== 1'b0 || dbg_drop_count !== 8'(exp_drop)) begin
            err_cnt++;
            $display("FAIL unsup_op: v=%b drop=%0d want 0/%0d",
                     rsp_valid, dbg_drop_count, exp_drop);
        end
`endif
        send(3'd0, 3'd4, 8'd7, 8'd6, 64'h8000_0000, 64'd0, 8'h00, 1'b1);
`ifdef SERIALTL_RESP_DENY_UNSUPPORTED_EN
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd1, 8'd7, 8'd6, 64'd0, 1'b1, 1'b1)) begin
            err_cnt++;
            $display("FAIL oversize: got %h", g);
        end
`else
        exp_drop++;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== 1'b0 || dbg_drop_count !== 8'(exp_drop)) begin
            err_cnt++;
            $display("FAIL oversize: v=%b drop=%0d want 0/%0d",
                     rsp_valid, dbg_drop_count, exp_drop);
        end
`endif
        send(3'd0, 3'd0, 8'd4, 8'd2, 64'h8000_0200, 64'hA, 8'h00, 1'b0);
        send(3'd2, 3'd0, 8'd3, 8'd2, 64'h8000_0200, 64'hEE, 8'h00, 1'b1);
        exp_drop++;
        send(3'd0, 3'd0, 8'd4, 8'd2, 64'h8000_0200, 64'hB, 8'h00, 1'b1);
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd0, 8'd4, 8'd2, 64'd0, 1'b0, 1'b1) ||
            dbg_drop_count !== 8'(exp_drop)) begin
            err_cnt++;
            $display("FAIL drop_in_burst: got %h drop=%0d want drop %0d",
                     g, dbg_drop_count, exp_drop);
        end
        send(3'd0, 3'd4, 8'd4, 8'd2, 64'h8000_0200, 64'd0, 8'h00, 1'b1);
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd1, 8'd4, 8'd2, 64'hA, 1'b0, 1'b0)) begin
            err_cnt++;
            $display("FAIL drop_burst_rd0: got %h", g);
        end
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd1, 8'd4, 8'd2, 64'hB, 1'b0, 1'b1)) begin
            err_cnt++;
            $display("FAIL drop_burst_rd1: got %h", g);
        end
    endtask

    task automatic test_reset_mid_burst();
        send(3'd0, 3'd0, 8'd5, 8'd8, 64'h8000_0300, 64'd5, 8'h00, 1'b0);
        send(3'd0, 3'd0, 8'd5, 8'd8, 64'h8000_0300, 64'd6, 8'h00, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({rsp_valid, req_ready, dbg_state, dbg_drop_count, rsp_all} !== '0) begin
            err_cnt++;
            $display("FAIL mid_reset_outputs: v=%b r=%b st=%0d drop=%0d want all 0",
                     rsp_valid, req_ready, dbg_state, dbg_drop_count);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== 1'b0 || dbg_state !== 3'd0 || req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_reset_noack: v=%b st=%0d r=%b want 0/0/1",
                     rsp_valid, dbg_state, req_ready);
        end
        send(3'd0, 3'd4, 8'd3, 8'd5, 64'h8000_0010, 64'd0, 8'h00, 1'b1);
        wait_rsp(g);
        vec_cnt++;
        if (g !== mk(3'd1, 8'd3, 8'd5, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1)) begin
            err_cnt++;
            $display("FAIL post_reset_get: got %h", g);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid   = 1'b0;
        req_chanId  = '0;
        req_opcode  = '0;
        req_param   = '0;
        req_size    = '0;
        req_source  = '0;
        req_address = '0;
        req_data    = '0;
        req_corrupt = 1'b0;
        req_union   = '0;
        req_last    = 1'b0;
        rsp_ready   = 1'b0;
        test_reset();
        test_put_get_single();
        test_partial_mask();
        test_burst();
        test_backpressure();
        test_out_of_range();
        test_drops();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
